rdptr_h_ctrl: RTL and testbench
===============================

Name: rdptr_h_ctrl

Overview:
Read-side pointer controller for the dual-clock FIFO. It is the read-end counterpart of the write pointer handler and runs entirely in the read clock domain. It synchronises the write-domain Gray pointer, converts it to binary, and maintains the binary and Gray read pointers and the memory read address. It generates registered empty, almost-empty, fill-count, read-valid and sticky underflow status for the FIFO consumer.

Parameters:
PTR_WIDTH, 3, address bits; pointers are PTR_WIDTH+1 bits wide; depth is 2^PTR_WIDTH.
AE_THRESH, 1, fifo_almost_empty asserts when the fill count is <= AE_THRESH; legal range 0..2^PTR_WIDTH.

Ports:
rdclk  input  1  read-domain clock; all flops are on its rising edge.
rdrst  input  1  synchronous, active-high reset (read domain).
rd_en  input  1  consumer pop request.
g_wrptr_async  input  PTR_WIDTH+1  write-domain Gray write pointer; unsynchronised.
b_rdptr  output  PTR_WIDTH+1  binary read pointer, registered.
g_rdptr  output  PTR_WIDTH+1  Gray read pointer, registered; sent to the write domain.
rd_addr  output  PTR_WIDTH  memory read address, equal to b_rdptr[PTR_WIDTH-1:0] (combinational).
fifo_empty  output  1  registered empty flag.
fifo_almost_empty  output  1  registered almost-empty flag.
rd_count  output  PTR_WIDTH+1  registered fill level, 0..2^PTR_WIDTH.
rd_valid  output  1  registered pop; memory data is valid in the cycle this flag is high.
underflow  output  1  sticky error flag.

Behaviour:
- Reset: on a rdclk edge with rdrst=1, all registers load their reset values; rdrst has no asynchronous path.
  - b_rdptr=0, g_rdptr=0, rd_count=0, rd_valid=0, underflow=0.
  - fifo_empty=1, fifo_almost_empty=1.
  - Both synchroniser stages load 0.
- Synchroniser: two flops, sync1 <= g_wrptr_async, sync2 <= sync1. Only sync2 is used downstream.
- Gray-to-binary: b_wrptr_sync[PTR_WIDTH] = sync2[PTR_WIDTH]; b_wrptr_sync[i] = b_wrptr_sync[i+1] ^ sync2[i].
- Pop: pop = rd_en & !fifo_empty, using the registered flag.
- Pointer update: b_rdptr_next = b_rdptr + pop, modulo 2^(PTR_WIDTH+1); g_rdptr_next = (b_rdptr_next>>1) ^ b_rdptr_next.
  - Both pointers register their next values every cycle.
- Empty: fifo_empty <= (g_rdptr_next == sync2), a full-width compare including the MSB.
  - The flag asserts on the same edge that takes the last entry; there is no extra bubble.
- Count: rd_count <= (b_wrptr_sync - b_rdptr_next), modulo 2^(PTR_WIDTH+1).
- Almost-empty: fifo_almost_empty <= (count_next <= AE_THRESH).
- rd_valid: rd_valid <= pop. The memory has a one-cycle synchronous read, so data for address A is valid in the cycle after A is popped.
- Underflow: underflow <= underflow | (rd_en & fifo_empty); it clears only on rdrst.
- Latency:
  - A change on g_wrptr_async that is stable before edge N reaches sync2 at edge N+1.
  - fifo_empty and rd_count reflect it at edge N+2, i.e. three edges counting the capture edge.
  - A pop is reflected in the pointers and flags at the same edge.
- Boundaries:
  - Wrap: b_rdptr goes 2^(PTR_WIDTH+1)-1 -> 0; for PTR_WIDTH=3 that is binary 15 -> 0 and Gray 1000 -> 0000. Count arithmetic stays modular across the wrap.
  - rd_en while empty: no pointer movement, rd_valid=0, underflow sets.
  - Pop and synchronised write advance on the same edge: count is unchanged and empty stays 0.
  - Reset mid-operation: all state clears. Empty reads 1 until the un-reset write pointer propagates (3 edges), then rd_count equals the write pointer value measured from 0.
  - fifo_empty, fifo_almost_empty and rd_count never glitch; they are registered.

Test Plan:
1. Hold rdrst=1 for 2 edges with rd_en=1 and g_wrptr_async=0101 -> after the reset edges: b_rdptr=0, g_rdptr=0, fifo_empty=1, fifo_almost_empty=1, rd_count=0, rd_valid=0, underflow=0.
2. After reset, drive g_wrptr_async 0000->0001 with rd_en=0 -> fifo_empty falls at the 3rd edge, rd_count=1, almost_empty stays 1. Then drive 0011 -> rd_count=2 and almost_empty=0 three edges later.
3. Drive g_wrptr_async=1100 (binary 8), wait for rd_count=8, then pop 8 consecutive cycles -> rd_addr steps 0..7 and rd_valid is high for 8 cycles, each lagging its pop by one. On the edge of the 8th pop: b_rdptr=8, g_rdptr=1100, fifo_empty=1, rd_count=0.
4. With fifo_empty=1, assert rd_en for 1 cycle -> pointers hold, rd_valid=0, underflow=1. Underflow stays 1 through later normal pops until rdrst.
5. Wrap: preload b_rdptr to 14 via pops, then set g_wrptr_async=0001 (binary 1) -> rd_count=3. Three pops give b_rdptr sequence 15,0,1 and g_rdptr 1000,0000,0001; fifo_empty=1 at the 3rd pop.
6. With rd_count=4, pop on the same edge that sync2 advances by 1 -> rd_count stays 4 and fifo_empty stays 0. Then assert rdrst mid-stream -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/rdptr_h_ctrl.sv
// Read-side FIFO pointer control: synchronises the write Gray pointer, tracks read pointers, and registers status flags.
// Latency: a pop updates pointers and flags on the same edge. A write pointer change appears in the flags two edges after it is captured. rd_en while empty is ignored and sets underflow.
module rdptr_h_ctrl #(
    parameter int PTR_WIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rdclk,
    input  logic                 rdrst,
    input  logic                 rd_en,
    input  logic [PTR_WIDTH:0]   g_wrptr_async,
    output logic [PTR_WIDTH:0]   b_rdptr,
    output logic [PTR_WIDTH:0]   g_rdptr,
    output logic [PTR_WIDTH-1:0] rd_addr,
    output logic                 fifo_empty,
    output logic                 fifo_almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 rd_valid,
    output logic                 underflow
);

    localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

    logic [PTR_WIDTH:0] sync1;
    logic [PTR_WIDTH:0] sync2;
    logic [PTR_WIDTH:0] b_wrptr_sync;
    logic [PTR_WIDTH:0] b_rdptr_next;
    logic [PTR_WIDTH:0] g_rdptr_next;
    logic [PTR_WIDTH:0] count_next;
    logic               pop;

    // Two-flop synchroniser. Only sync2 is considered stable enough to decode.
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= g_wrptr_async;
            sync2 <= sync1;
        end
    end

    always_comb begin
        b_wrptr_sync            = '0;
        b_wrptr_sync[PTR_WIDTH] = sync2[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b_wrptr_sync[i] = b_wrptr_sync[i+1] ^ sync2[i];
        end
    end

    always_comb begin
        pop          = rd_en & ~fifo_empty;
        b_rdptr_next = b_rdptr + {{PTR_WIDTH{1'b0}}, pop};
        g_rdptr_next = (b_rdptr_next >> 1) ^ b_rdptr_next;
        count_next   = b_wrptr_sync - b_rdptr_next;
    end

    // Flags are computed from the next read pointer, so the last pop asserts empty with no bubble.
    always_ff @(posedge rdclk) begin
        if (rdrst) begin
            b_rdptr           <= '0;
            g_rdptr           <= '0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
            rd_count          <= '0;
            rd_valid          <= 1'b0;
            underflow         <= 1'b0;
        end else begin
            b_rdptr           <= b_rdptr_next;
            g_rdptr           <= g_rdptr_next;
            fifo_empty        <= (g_rdptr_next == sync2);
            fifo_almost_empty <= (count_next <= AE_T);
            rd_count          <= count_next;
            rd_valid          <= pop;
            underflow         <= underflow | (rd_en & fifo_empty);
        end
    end

    assign rd_addr = b_rdptr[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_rdptr_h_ctrl.sv
// Bench for rdptr_h_ctrl. Directed scenarios are followed by random traffic.
// Each cycle is checked against an occupancy model built from integer pointers and a queue that models the two-flop delay.
module tb_rdptr_h_ctrl;

    localparam int PW   = 3;
    localparam int AE   = 1;
    localparam int MASK = (1 << (PW + 1)) - 1;

    logic          rdclk = 1'b0;
    logic          rdrst = 1'b1;
    logic          rd_en = 1'b0;
    logic [PW:0]   g_wrptr_async = '0;
    logic [PW:0]   b_rdptr;
    logic [PW:0]   g_rdptr;
    logic [PW-1:0] rd_addr;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [PW:0]   rd_count;
    logic          rd_valid;
    logic          underflow;

    rdptr_h_ctrl #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
        .rdclk             (rdclk),
        .rdrst             (rdrst),
        .rd_en             (rd_en),
        .g_wrptr_async     (g_wrptr_async),
        .b_rdptr           (b_rdptr),
        .g_rdptr           (g_rdptr),
        .rd_addr           (rd_addr),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .rd_count          (rd_count),
        .rd_valid          (rd_valid),
        .underflow         (underflow)
    );

    always #5 rdclk = ~rdclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    int m_rp, m_cnt;
    bit m_empty, m_ae, m_valid, m_uf;
    int wq[$];

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit en, input int w);
        bit pop;
        int ws;
        @(negedge rdclk);
        rdrst         = rst;
        rd_en         = en;
        g_wrptr_async = (PW+1)'(to_gray(w & MASK));
        @(posedge rdclk);
        if (rst) begin
            m_rp = 0; m_cnt = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
            wq = '{0, 0};
        end else begin
            pop     = en && !m_empty;
            m_uf    = m_uf || (en && m_empty);
            m_rp    = (m_rp + int'(pop)) & MASK;
            ws      = wq.pop_front();
            m_cnt   = (ws - m_rp) & MASK;
            m_empty = (m_cnt == 0);
            m_ae    = (m_cnt <= AE);
            m_valid = pop;
            wq.push_back(w & MASK);
        end
        #1;
        check("b_rdptr",      32'(b_rdptr),           32'(m_rp));
        check("g_rdptr",      32'(g_rdptr),           32'(to_gray(m_rp)));
        check("rd_addr",      32'(rd_addr),           32'(m_rp & ((1 << PW) - 1)));
        check("fifo_empty",   32'(fifo_empty),        32'(m_empty));
        check("almost_empty", 32'(fifo_almost_empty), 32'(m_ae));
        check("rd_count",     32'(rd_count),          32'(m_cnt));
        check("rd_valid",     32'(rd_valid),          32'(m_valid));
        check("underflow",    32'(underflow),         32'(m_uf));
    endtask

    initial begin
        int w, occ;
        int exp_b[3];
        int exp_g[3];

        // Reset with rd_en high and a nonzero write pointer present.
        step(1, 1, 6);
        step(1, 1, 6);
        check("rst_b", 32'(b_rdptr), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_ae", 32'(fifo_almost_empty), 1);
        check("rst_uf", 32'(underflow), 0);

        // Single write, then second write: empty falls on the third edge after capture.
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        check("lat_empty_still", 32'(fifo_empty), 1);
        step(0, 0, 1);
        check("lat_empty_fall", 32'(fifo_empty), 0);
        check("lat_cnt1", 32'(rd_count), 1);
        check("lat_ae1", 32'(fifo_almost_empty), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 2);
        check("cnt2", 32'(rd_count), 2);
        check("ae_cnt2", 32'(fifo_almost_empty), 0);

        // Fill to 8 entries, then drain them back-to-back.
        for (int i = 0; i < 3; i++) step(0, 0, 8);
        check("cnt8", 32'(rd_count), 8);
        for (int i = 0; i < 8; i++) begin
            check("drain_addr", 32'(rd_addr), 32'(i));
            step(0, 1, 8);
        end
        check("drain_b", 32'(b_rdptr), 8);
        check("drain_g", 32'(g_rdptr), 32'b1100);
        check("drain_empty", 32'(fifo_empty), 1);
        check("drain_cnt", 32'(rd_count), 0);
        check("drain_valid8", 32'(rd_valid), 1);

        // Read while empty.
        step(0, 1, 8);
        check("uf_set", 32'(underflow), 1);
        check("uf_hold_b", 32'(b_rdptr), 8);
        check("uf_valid", 32'(rd_valid), 0);

        // Pointer wrap: advance the read pointer to 14, then let the write pointer wrap to 1.
        for (int i = 0; i < 3; i++) step(0, 0, 14);
        for (int i = 0; i < 6; i++) step(0, 1, 14);
        check("pre_wrap_b", 32'(b_rdptr), 14);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("wrap_cnt", 32'(rd_count), 3);
        exp_b = '{15, 0, 1};
        exp_g = '{32'b1000, 32'b0000, 32'b0001};
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            check("wrap_b", 32'(b_rdptr), 32'(exp_b[i]));
            check("wrap_g", 32'(g_rdptr), 32'(exp_g[i]));
        end
        check("wrap_empty", 32'(fifo_empty), 1);
        check("uf_sticky", 32'(underflow), 1);

        // A pop and a synchronised write landing on the same edge leave the count unchanged.
        for (int i = 0; i < 3; i++) step(0, 0, 5);
        check("sim_cnt_pre", 32'(rd_count), 4);
        step(0, 0, 6);
        step(0, 0, 6);
        step(0, 1, 6);
        check("sim_cnt", 32'(rd_count), 4);
        check("sim_empty", 32'(fifo_empty), 0);

        // Mid-stream reset while the write pointer stays at 6.
        step(1, 1, 6);
        check("mrst_b", 32'(b_rdptr), 0);
        check("mrst_cnt", 32'(rd_count), 0);
        check("mrst_empty", 32'(fifo_empty), 1);
        check("mrst_uf", 32'(underflow), 0);
        step(0, 0, 6);
        step(0, 0, 6);
        check("mrst_empty2", 32'(fifo_empty), 1);
        step(0, 0, 6);
        check("mrst_cnt3", 32'(rd_count), 6);

        // Random traffic; the writer never overfills based on the model's read pointer.
        w = 6;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                w = 0;
                step(1, 1'($urandom_range(0, 1)), w);
            end else begin
                occ = (w - m_rp) & MASK;
                if (occ < (1 << PW) && $urandom_range(0, 99) < 55) w = (w + 1) & MASK;
                step(0, 1'($urandom_range(0, 99) < 50), w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
